// File: rtl/pc_pkg.sv
// Shared sizing and types for the per-thread program-counter block.
// pc_unit and pc_regfile both import this package.
package pc_pkg;

  localparam int N_THREADS = 8;
  localparam int PC_W      = 10;
  localparam int TID_W     = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [TID_W-1:0] tid_t;

  // Sequential successor of a PC, wrapping at the top of the address space
  function automatic pc_t pcIncr(pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/pc_regfile.sv
// Per-thread PC storage with two write ports (start, writeback) and one read
// port that sees this cycle's writes to the same thread.
module pc_regfile
  import pc_pkg::*;
#(
  parameter int N_THREADS = pc_pkg::N_THREADS,
  parameter int PC_W      = pc_pkg::PC_W,
  parameter int TID_BITS  = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                startWe_i,
  input  logic [TID_BITS-1:0] startTid_i,
  input  logic [PC_W-1:0]     startPc_i,
  input  logic                wbWe_i,
  input  logic [TID_BITS-1:0] wbTid_i,
  input  logic                wbBr_i,
  input  logic [PC_W-1:0]     wbTarget_i,
  input  logic [TID_BITS-1:0] rdTid_i,
  output logic [PC_W-1:0]     rdPc_o
);

  logic [PC_W-1:0] mem_q [N_THREADS];
  logic [PC_W-1:0] mem_d [N_THREADS];
  logic [PC_W-1:0] wbPc;

  always_comb begin
    wbPc = wbBr_i ? wbTarget_i : (mem_q[wbTid_i] + PC_W'(1));
  end

  // Start is applied after writeback so it wins on a shared thread; the read
  // port looks at next-state, which makes the same-cycle bypass free.
  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      mem_d[i] = mem_q[i];
      if (wbWe_i && (wbTid_i == TID_BITS'(i))) begin
        mem_d[i] = wbPc;
      end
      if (startWe_i && (startTid_i == TID_BITS'(i))) begin
        mem_d[i] = startPc_i;
      end
    end
    rdPc_o = mem_d[rdTid_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_THREADS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Multithreaded PC unit: per-thread PCs, a two-stage fetch pipeline to the
// instruction memory, in-flight hazard tracking and a retirement counter.
module pc_unit
  import pc_pkg::*;
#(
  parameter int N_THREADS = pc_pkg::N_THREADS,
  parameter int PC_W      = pc_pkg::PC_W,
  parameter int TID_BITS  = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                clk,
  input  logic                c_sys_rst_n,
  input  logic                c_start,
  input  logic [TID_BITS-1:0] start_tid,
  input  logic [PC_W-1:0]     pc_set,
  input  logic                c_fetch_req,
  input  logic [TID_BITS-1:0] fetch_tid,
  input  logic                c_wb_valid,
  input  logic [TID_BITS-1:0] wb_tid,
  input  logic                c_br_taken,
  input  logic [PC_W-1:0]     br_target,
  output logic [PC_W-1:0]     imem_addr,
  output logic                c_imem_rd,
  output logic [TID_BITS-1:0] imem_tid,
  output logic [31:0]         retired_cnt,
  output logic                c_hazard_err
);

  logic [PC_W-1:0]      rdPc;

  logic                 f1Valid_q;
  logic [TID_BITS-1:0]  f1Tid_q;
  logic [PC_W-1:0]      f1Pc_q;

  logic                 imemRd_q;
  logic [PC_W-1:0]      imemAddr_q;
  logic [TID_BITS-1:0]  imemTid_q;

  logic [N_THREADS-1:0] inFlight_q;
  logic [N_THREADS-1:0] inFlight_d;
  logic                 hazardErr_q;
  logic                 hazardErr_d;
  logic                 hazardHit;
  logic [31:0]          retiredCnt_q;

  pc_regfile #(
    .N_THREADS (N_THREADS),
    .PC_W      (PC_W),
    .TID_BITS  (TID_BITS)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (c_sys_rst_n),
    .startWe_i  (c_start),
    .startTid_i (start_tid),
    .startPc_i  (pc_set),
    .wbWe_i     (c_wb_valid),
    .wbTid_i    (wb_tid),
    .wbBr_i     (c_br_taken),
    .wbTarget_i (br_target),
    .rdTid_i    (fetch_tid),
    .rdPc_o     (rdPc)
  );

  always_ff @(posedge clk or negedge c_sys_rst_n) begin
    if (!c_sys_rst_n) begin
      f1Valid_q  <= 1'b0;
      f1Tid_q    <= '0;
      f1Pc_q     <= '0;
      imemRd_q   <= 1'b0;
      imemAddr_q <= '0;
      imemTid_q  <= '0;
    end else begin
      f1Valid_q <= c_fetch_req;
      if (c_fetch_req) begin
        f1Tid_q <= fetch_tid;
        f1Pc_q  <= rdPc;
      end
      imemRd_q <= f1Valid_q;
      if (f1Valid_q) begin
        imemAddr_q <= f1Pc_q;
        imemTid_q  <= f1Tid_q;
      end
    end
  end

  // Order matters: a fetch re-arms its thread even if a retire or start
  // clears it in the same cycle.
  always_comb begin
    inFlight_d = inFlight_q;
    if (c_wb_valid) begin
      inFlight_d[wb_tid] = 1'b0;
    end
    if (c_start) begin
      inFlight_d[start_tid] = 1'b0;
    end
    if (c_fetch_req) begin
      inFlight_d[fetch_tid] = 1'b1;
    end
  end

  always_comb begin
    hazardHit   = c_fetch_req && inFlight_q[fetch_tid] &&
                  !(c_wb_valid && (wb_tid == fetch_tid));
    hazardErr_d = hazardErr_q | hazardHit;
  end

  always_ff @(posedge clk or negedge c_sys_rst_n) begin
    if (!c_sys_rst_n) begin
      inFlight_q   <= '0;
      hazardErr_q  <= 1'b0;
      retiredCnt_q <= '0;
    end else begin
      inFlight_q  <= inFlight_d;
      hazardErr_q <= hazardErr_d;
      if (c_wb_valid) begin
        retiredCnt_q <= retiredCnt_q + 32'd1;
      end
    end
  end

  assign imem_addr    = imemAddr_q;
  assign c_imem_rd    = imemRd_q;
  assign imem_tid     = imemTid_q;
  assign retired_cnt  = retiredCnt_q;
  assign c_hazard_err = hazardErr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit; each task drives one scenario and checks
// the fetch outputs, hazard flag and retirement count against hand values.
module tb_pc_unit;

  logic        clk;
  logic        c_sys_rst_n;
  logic        c_start;
  logic [2:0]  start_tid;
  logic [9:0]  pc_set;
  logic        c_fetch_req;
  logic [2:0]  fetch_tid;
  logic        c_wb_valid;
  logic [2:0]  wb_tid;
  logic        c_br_taken;
  logic [9:0]  br_target;
  logic [9:0]  imem_addr;
  logic        c_imem_rd;
  logic [2:0]  imem_tid;
  logic [31:0] retired_cnt;
  logic        c_hazard_err;

  int vecCount  = 0;
  int missCount = 0;

  pc_unit dut (
    .clk          (clk),
    .c_sys_rst_n  (c_sys_rst_n),
    .c_start      (c_start),
    .start_tid    (start_tid),
    .pc_set       (pc_set),
    .c_fetch_req  (c_fetch_req),
    .fetch_tid    (fetch_tid),
    .c_wb_valid   (c_wb_valid),
    .wb_tid       (wb_tid),
    .c_br_taken   (c_br_taken),
    .br_target    (br_target),
    .imem_addr    (imem_addr),
    .c_imem_rd    (c_imem_rd),
    .imem_tid     (imem_tid),
    .retired_cnt  (retired_cnt),
    .c_hazard_err (c_hazard_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (actual timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    c_start     = 1'b0;
    start_tid   = 3'd0;
    pc_set      = 10'h000;
    c_fetch_req = 1'b0;
    fetch_tid   = 3'd0;
    c_wb_valid  = 1'b0;
    wb_tid      = 3'd0;
    c_br_taken  = 1'b0;
    br_target   = 10'h000;
  endtask

  task automatic doReset();
    idleInputs();
    c_sys_rst_n = 1'b0;
    #3;
    @(posedge clk);
    #1;
    c_sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idleInputs();
    c_sys_rst_n = 1'b0;
    #2;
    vecCount++;
    if (c_imem_rd !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_rd: got %b want 0", c_imem_rd);
    end
    vecCount++;
    if (imem_addr !== 10'h000 || imem_tid !== 3'd0) begin
      missCount++;
      $display("[TB] FAIL reset_addr: got addr %h tid %0d want 000/0", imem_addr, imem_tid);
    end
    vecCount++;
    if (retired_cnt !== 32'd0 || c_hazard_err !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_cnt_err: got cnt %0d err %b want 0/0", retired_cnt, c_hazard_err);
    end
    @(posedge clk);
    #1;
    c_sys_rst_n = 1'b1;
    tick();
    vecCount++;
    if (c_imem_rd !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL reset_idle_rd: got %b want 0", c_imem_rd);
    end
  endtask

  task automatic test_start_fetch();
    doReset();
    c_start = 1'b1; start_tid = 3'd3; pc_set = 10'h040;
    tick();
    c_start = 1'b0;
    c_fetch_req = 1'b1; fetch_tid = 3'd3;
    tick();
    c_fetch_req = 1'b0;
    vecCount++;
    if (c_imem_rd !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL start_latency1: got rd %b want 0", c_imem_rd);
    end
    tick();
    vecCount++;
    if (c_imem_rd !== 1'b1 || imem_addr !== 10'h040 || imem_tid !== 3'd3) begin
      missCount++;
      $display("[TB] FAIL start_fetch: got rd %b addr %h tid %0d want 1/040/3", c_imem_rd, imem_addr, imem_tid);
    end
    tick();
    vecCount++;
    if (c_imem_rd !== 1'b0 || imem_addr !== 10'h040 || imem_tid !== 3'd3) begin
      missCount++;
      $display("[TB] FAIL start_hold: got rd %b addr %h tid %0d want 0/040/3", c_imem_rd, imem_addr, imem_tid);
    end
  endtask

  task automatic test_pc_wrap();
    doReset();
    c_start = 1'b1; start_tid = 3'd2; pc_set = 10'h3FF;
    tick();
    c_start = 1'b0;
    c_wb_valid = 1'b1; wb_tid = 3'd2; c_br_taken = 1'b0; br_target = 10'h155;
    tick();
    // retire-shaped inputs with c_wb_valid low must have no effect
    c_wb_valid = 1'b0; wb_tid = 3'd2; c_br_taken = 1'b1; br_target = 10'h2AA;
    c_fetch_req = 1'b1; fetch_tid = 3'd2;
    tick();
    idleInputs();
    tick();
    vecCount++;
    if (c_imem_rd !== 1'b1 || imem_addr !== 10'h000 || imem_tid !== 3'd2) begin
      missCount++;
      $display("[TB] FAIL pc_wrap: got rd %b addr %h tid %0d want 1/000/2", c_imem_rd, imem_addr, imem_tid);
    end
    vecCount++;
    if (retired_cnt !== 32'd1) begin
      missCount++;
      $display("[TB] FAIL wrap_retired: got %0d want 1", retired_cnt);
    end
  endtask

  task automatic test_bypass();
    doReset();
    c_wb_valid = 1'b1; wb_tid = 3'd5; c_br_taken = 1'b1; br_target = 10'h123;
    c_fetch_req = 1'b1; fetch_tid = 3'd5;
    tick();
    c_wb_valid = 1'b1; wb_tid = 3'd0; c_br_taken = 1'b0; br_target = 10'h3C3;
    c_fetch_req = 1'b1; fetch_tid = 3'd0;
    tick();
    idleInputs();
    vecCount++;
    if (c_imem_rd !== 1'b1 || imem_addr !== 10'h123 || imem_tid !== 3'd5) begin
      missCount++;
      $display("[TB] FAIL bypass_branch: got rd %b addr %h tid %0d want 1/123/5", c_imem_rd, imem_addr, imem_tid);
    end
    tick();
    vecCount++;
    if (c_imem_rd !== 1'b1 || imem_addr !== 10'h001 || imem_tid !== 3'd0) begin
      missCount++;
      $display("[TB] FAIL bypass_incr: got rd %b addr %h tid %0d want 1/001/0", c_imem_rd, imem_addr, imem_tid);
    end
    vecCount++;
    if (retired_cnt !== 32'd2 || c_hazard_err !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL bypass_cnt_err: got cnt %0d err %b want 2/0", retired_cnt, c_hazard_err);
    end
  endtask

  task automatic test_start_priority();
    doReset();
    c_start = 1'b1; start_tid = 3'd1; pc_set = 10'h010;
    c_wb_valid = 1'b1; wb_tid = 3'd1; c_br_taken = 1'b1; br_target = 10'h200;
    tick();
    c_start = 1'b1; start_tid = 3'd6; pc_set = 10'h055;
    c_wb_valid = 1'b1; wb_tid = 3'd7; c_br_taken = 1'b1; br_target = 10'h077;
    tick();
    idleInputs();
    c_fetch_req = 1'b1; fetch_tid = 3'd1;
    tick();
    fetch_tid = 3'd6;
    tick();
    vecCount++;
    if (c_imem_rd !== 1'b1 || imem_addr !== 10'h010 || imem_tid !== 3'd1) begin
      missCount++;
      $display("[TB] FAIL start_wins: got rd %b addr %h tid %0d want 1/010/1", c_imem_rd, imem_addr, imem_tid);
    end
    fetch_tid = 3'd7;
    tick();
    vecCount++;
    if (c_imem_rd !== 1'b1 || imem_addr !== 10'h055 || imem_tid !== 3'd6) begin
      missCount++;
      $display("[TB] FAIL dual_write_start: got rd %b addr %h tid %0d want 1/055/6", c_imem_rd, imem_addr, imem_tid);
    end
    c_fetch_req = 1'b1; fetch_tid = 3'd2;
    c_start = 1'b1; start_tid = 3'd2; pc_set = 10'h0AB;
    tick();
    idleInputs();
    vecCount++;
    if (c_imem_rd !== 1'b1 || imem_addr !== 10'h077 || imem_tid !== 3'd7) begin
      missCount++;
      $display("[TB] FAIL dual_write_wb: got rd %b addr %h tid %0d want 1/077/7", c_imem_rd, imem_addr, imem_tid);
    end
    tick();
    vecCount++;
    if (c_imem_rd !== 1'b1 || imem_addr !== 10'h0AB || imem_tid !== 3'd2) begin
      missCount++;
      $display("[TB] FAIL start_bypass: got rd %b addr %h tid %0d want 1/0AB/2", c_imem_rd, imem_addr, imem_tid);
    end
    tick();
    vecCount++;
    if (c_imem_rd !== 1'b0 || retired_cnt !== 32'd2 || c_hazard_err !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL priority_tail: got rd %b cnt %0d err %b want 0/2/0", c_imem_rd, retired_cnt, c_hazard_err);
    end
  endtask

  task automatic test_hazard();
    doReset();
    c_fetch_req = 1'b1; fetch_tid = 3'd4;
    tick();
    vecCount++;
    if (c_hazard_err !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL hazard_first: got %b want 0", c_hazard_err);
    end
    tick();
    c_fetch_req = 1'b0;
    vecCount++;
    if (c_hazard_err !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL hazard_second: got %b want 1", c_hazard_err);
    end
    c_wb_valid = 1'b1; wb_tid = 3'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    idleInputs();
    tick();
    vecCount++;
    if (retired_cnt !== 32'd3 || c_hazard_err !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL hazard_sticky_cnt: got cnt %0d err %b want 3/1", retired_cnt, c_hazard_err);
    end
    doReset();
    vecCount++;
    if (c_hazard_err !== 1'b0 || retired_cnt !== 32'd0) begin
      missCount++;
      $display("[TB] FAIL hazard_cleared: got err %b cnt %0d want 0/0", c_hazard_err, retired_cnt);
    end
  endtask

  task automatic test_hazard_exempt();
    doReset();
    c_fetch_req = 1'b1; fetch_tid = 3'd0;
    tick();
    c_wb_valid = 1'b1; wb_tid = 3'd0;
    tick();
    idleInputs();
    vecCount++;
    if (c_hazard_err !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL hazard_wb_same_cycle: got %b want 0", c_hazard_err);
    end
    c_start = 1'b1; start_tid = 3'd0; pc_set = 10'h100;
    tick();
    idleInputs();
    c_fetch_req = 1'b1; fetch_tid = 3'd0;
    tick();
    idleInputs();
    vecCount++;
    if (c_hazard_err !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL hazard_start_clears: got %b want 0", c_hazard_err);
    end
    tick();
    vecCount++;
    if (c_imem_rd !== 1'b1 || imem_addr !== 10'h100 || imem_tid !== 3'd0) begin
      missCount++;
      $display("[TB] FAIL restart_fetch: got rd %b addr %h tid %0d want 1/100/0", c_imem_rd, imem_addr, imem_tid);
    end
  endtask

  task automatic test_reset_midflight();
    doReset();
    c_start = 1'b1; start_tid = 3'd3; pc_set = 10'h2C0;
    tick();
    idleInputs();
    c_fetch_req = 1'b1; fetch_tid = 3'd3;
    tick();
    fetch_tid = 3'd4;
    tick();
    idleInputs();
    vecCount++;
    if (c_imem_rd !== 1'b1 || imem_addr !== 10'h2C0) begin
      missCount++;
      $display("[TB] FAIL midflight_pre: got rd %b addr %h want 1/2C0", c_imem_rd, imem_addr);
    end
    #2;
    c_sys_rst_n = 1'b0;
    #1;
    vecCount++;
    if (c_imem_rd !== 1'b0 || imem_addr !== 10'h000 || imem_tid !== 3'd0) begin
      missCount++;
      $display("[TB] FAIL midflight_async: got rd %b addr %h tid %0d want 0/000/0", c_imem_rd, imem_addr, imem_tid);
    end
    @(posedge clk);
    #1;
    c_sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecCount++;
      if (c_imem_rd !== 1'b0) begin
        missCount++;
        $display("[TB] FAIL midflight_drop[%0d]: got rd %b want 0", i, c_imem_rd);
      end
    end
    c_fetch_req = 1'b1; fetch_tid = 3'd1;
    tick();
    idleInputs();
    vecCount++;
    if (c_imem_rd !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL post_reset_early: got rd %b want 0", c_imem_rd);
    end
    tick();
    vecCount++;
    if (c_imem_rd !== 1'b1 || imem_addr !== 10'h000 || imem_tid !== 3'd1) begin
      missCount++;
      $display("[TB] FAIL post_reset_fetch: got rd %b addr %h tid %0d want 1/000/1", c_imem_rd, imem_addr, imem_tid);
    end
  endtask

  initial begin
    c_sys_rst_n = 1'b1;
    idleInputs();
    test_reset();
    test_start_fetch();
    test_pc_wrap();
    test_bypass();
    test_start_priority();
    test_hazard();
    test_hazard_exempt();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: c_sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: c_start  in  1  thread-start request from thread controller (stage-6 aligned).
REQ-004 SHALL have port: start_tid  in  3  thread being started.
REQ-005 SHALL have port: pc_set  in  10  start PC for start_tid.
REQ-006 SHALL have port: c_fetch_req  in  1  issue-slot valid (thread_pipe_valid slot).
REQ-007 SHALL have port: fetch_tid  in  3  thread occupying the issue slot (tid_rd0 timing).
REQ-008 SHALL have port: c_wb_valid  in  1  instruction retiring this cycle.
REQ-009 SHALL have port: wb_tid  in  3  retiring thread.
REQ-010 SHALL have port: c_br_taken  in  1  retiring instruction redirects.
REQ-011 SHALL have port: br_target  in  10  redirect target.
REQ-012 SHALL have port: imem_addr  out  10  instruction-memory read address.
REQ-013 SHALL have port: c_imem_rd  out  1  imem_addr valid.
REQ-014 SHALL have port: imem_tid  out  3  thread owning imem_addr.
REQ-015 SHALL have port: retired_cnt  out  32  total retired instructions.
REQ-016 SHALL have port: c_hazard_err  out  1  sticky: fetch of thread with instruction in flight.
REQ-017 SHALL have parameter: N_THREADS, default 8, thread count; PC_W, default 10, PC width.

Function
REQ-018 SHALL hold pc_mem: N_THREADS x PC_W registers, one per thread.
REQ-019 SHALL, on c_wb_valid, write pc_mem[wb_tid] <= c_br_taken ? br_target : pc_mem[wb_tid]+1, modulo 2^PC_W (0x3FF+1 -> 0x000).
REQ-020 SHALL, on c_start, write pc_mem[start_tid] <= pc_set.
REQ-021 SHALL give c_start priority over c_wb_valid when start_tid == wb_tid in same cycle; different tids both write.
REQ-022 SHALL, on c_fetch_req, read pc_mem[fetch_tid] with same-cycle bypass: value written this cycle to fetch_tid (per REQ-019..021) is used instead of stored value.
REQ-023 SHALL register read result into F1 then F2; imem_addr/imem_tid/c_imem_rd driven from F2: fixed latency 2 cycles, no back-pressure.
REQ-024 SHALL deassert c_imem_rd in any cycle whose F2 stage holds no request; imem_addr/imem_tid then hold last value.
REQ-025 SHALL keep in_flight[N_THREADS]: set for fetch_tid on c_fetch_req, cleared for wb_tid on c_wb_valid; set wins when same tid both.
REQ-026 SHALL set c_hazard_err when c_fetch_req targets a tid with in_flight=1 and no same-cycle c_wb_valid for that tid; clears only on reset.
REQ-027 SHALL clear in_flight[start_tid] on c_start (start discards stale in-flight state); c_fetch_req same tid same cycle still sets it.
REQ-028 SHALL increment retired_cnt by 1 per c_wb_valid, wrapping 0xFFFFFFFF -> 0.
REQ-029 SHALL ignore c_br_taken/br_target/wb_tid when c_wb_valid=0.

Reset
REQ-030 SHALL on c_sys_rst_n=0 asynchronously clear: pc_mem all 0, in_flight 0, F1/F2 valid 0, imem_addr 0, imem_tid 0, c_imem_rd 0, retired_cnt 0, c_hazard_err 0.
REQ-031 SHALL drop requests in F1/F2 when reset asserts mid-operation; first c_imem_rd earliest 2 cycles after first post-reset c_fetch_req.

Structure
REQ-032 SHALL place N_THREADS, PC_W, tid width (clog2 N_THREADS) and a pc_t typedef in a shared package, pc_pkg.
REQ-033 SHALL implement pc_mem with bypass/write priority as sub-module pc_regfile (1 read, 2 write ports); pipeline, in_flight, counter stay in pc_unit.

Verification
REQ-034 SHALL cover: reset, c_start tid=3 pc_set=0x040, then c_fetch_req tid=3 -> 2 cycles later c_imem_rd=1, imem_addr=0x040, imem_tid=3.
REQ-035 SHALL cover: pc_mem[2]=0x3FF, c_wb_valid tid=2 no branch, next fetch tid=2 -> imem_addr=0x000.
REQ-036 SHALL cover: same cycle c_wb_valid tid=5 c_br_taken target=0x123 and c_fetch_req tid=5 -> imem_addr=0x123 after 2 cycles (bypass).
REQ-037 SHALL cover: same cycle c_start tid=1 pc_set=0x010 and c_wb_valid tid=1 branch 0x200 -> later fetch tid=1 gives 0x010.
REQ-038 SHALL cover: c_fetch_req tid=4 twice with no retire between -> c_hazard_err=1 cycle after second request, stays 1 until reset; retired_cnt counts 3 after 3 retires.
REQ-039 SHALL cover: c_sys_rst_n low while F1/F2 valid -> c_imem_rd=0 immediately, no output after release without new request.
